seq_detect_param: RTL and testbench

// - Parametrised serial sequence detector; successor to the fixed single-pattern Mealy/Moore detectors.
// - Pattern (up to MAX_LEN bits) and length are runtime-loadable.
// - Overlapping/non-overlapping mode select, sample enable, saturating match counter.
// - Sits on a 1-bit serial stream x; z is a registered one-cycle match pulse.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_sat_counter.sv | 42 ++++
 rtl/seq_detect_param.sv | 119 +++++++++++
 tb/tb_seq_detect_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and types for the parametrised serial sequence detector.
// Widths here match the default MAX_LEN; the top re-derives them from its own parameters.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam logic [MAX_LEN_DEF-1:0] RST_PATTERN_DEF = 8'b0000_1100;
  localparam int RST_LEN_DEF = 4;

  // Length field must hold values 0..max_len inclusive.
  function automatic int lw_of(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  localparam int LW_DEF = lw_of(MAX_LEN_DEF);

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pattern;
    logic [LW_DEF-1:0]      len;
  } cfg_t;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating match counter with sticky saturation flag.
// clr and inc in the same cycle clear first, then count.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d, base;
  logic             sat_q, sat_d, sat_base;

  always_comb begin
    base     = clr ? '0 : count_q;
    sat_base = clr ? 1'b0 : sat_q;
    count_d  = base;
    if (inc && (base != CNT_MAX)) begin
      count_d = base + 1'b1;
    end
    sat_d = sat_base || (count_d == CNT_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector: shift history, fill tracking,
// masked compare on the next-state history, registered one-cycle match pulse.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = MAX_LEN_DEF,
  parameter int                 CNT_W       = CNT_W_DEF,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
  parameter int                 RST_LEN     = RST_LEN_DEF,
  localparam int                LW          = lw_of(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               x,
  input  logic               en,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
  } cfg_reg_t;

  cfg_reg_t           cfg_q, cfg_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n, len_mask;
  logic [LW-1:0]      fill_q, fill_d, fill_n;
  logic               z_q, z_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ok, match, cnt_clr_i;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  assign hist_n = {hist_q[MAX_LEN-2:0], x};
  assign fill_n = (fill_q >= LW'(MAX_LEN)) ? LW'(MAX_LEN) : fill_q + LW'(1);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_q.len));
    end
  end

  // A load cycle never samples x, so it can never produce a match.
  assign match = en && !cfg_load && (fill_n >= cfg_q.len) &&
                 ((hist_n & len_mask) == (cfg_q.pattern & len_mask));

  always_comb begin
    cfg_d     = cfg_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;
    cnt_clr_i = cnt_clr;
    if (cfg_load) begin
      cnt_clr_i = cfg_ok;
      if (cfg_ok) begin
        cfg_d.pattern = cfg_pattern;
        cfg_d.len     = cfg_len;
        hist_d        = '0;
        fill_d        = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_n;
      fill_d = (match && !overlap) ? '0 : fill_n;
    end
  end

  assign z_d = match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_q.pattern <= RST_PATTERN;
      cfg_q.len     <= LW'(RST_LEN);
    end else begin
      cfg_q <= cfg_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      z_q       <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      z_q       <= z_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  seq_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clr_i),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

  assign z       = z_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: default instance plus a CNT_W=2 instance on shared inputs,
// checked against a queue-of-bits reference model through an expected-value scoreboard.
module tb_seq_detect_param;

  localparam int ML    = 8;
  localparam int LW    = 4;
  localparam int EXP_W = 16;

  logic          clock, reset, x, en, overlap, cfg_load, cnt_clr;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          z, cnt_sat, cfg_err;
  logic [7:0]    match_cnt;
  logic          z2, sat2, err2;
  logic [1:0]    cnt2;

  logic [EXP_W-1:0] exp_q[$];
  int vec_cnt  = 0;
  int miscmp   = 0;

  // reference model state
  logic [ML-1:0] m_pat;
  int            m_len;
  bit            m_bits[$];
  int            m_cnt8, m_cnt2;
  bit            m_sat8, m_sat2;

  seq_detect_param u_dut (
    .clock(clock), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
    .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(cnt2), .cnt_sat(sat2),
    .cfg_err(err2)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset = 1'b0; x = 1'b0; en = 1'b0; overlap = 1'b0;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cnt_clr = 1'b0;
  end

  task automatic model_reset();
    m_pat  = 8'b0000_1100;
    m_len  = 4;
    m_bits.delete();
    m_cnt8 = 0; m_cnt2 = 0;
    m_sat8 = 1'b0; m_sat2 = 1'b0;
  endtask

  // driver: one clock of stimulus, model update, expected push
  task automatic step(input bit rst_i, input bit x_i, input bit en_i, input bit ov_i,
                      input bit ld_i, input logic [ML-1:0] pat_i, input logic [LW-1:0] len_i,
                      input bit clr_i);
    bit mz, merr, hit;
    @(negedge clock);
    reset = rst_i; x = x_i; en = en_i; overlap = ov_i;
    cfg_load = ld_i; cfg_pattern = pat_i; cfg_len = len_i; cnt_clr = clr_i;
    mz = 1'b0; merr = 1'b0;
    if (!rst_i) begin
      model_reset();
    end else if (ld_i) begin
      if (len_i >= 1 && int'(len_i) <= ML) begin
        m_pat = pat_i; m_len = int'(len_i);
        m_bits.delete();
        m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0;
      end else begin
        merr = 1'b1;
      end
    end else begin
      if (clr_i) begin
        m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0;
      end
      if (en_i) begin
        m_bits.push_back(x_i);
        if (m_bits.size() > ML) void'(m_bits.pop_front());
        hit = (m_bits.size() >= m_len);
        if (hit) begin
          for (int k = 0; k < m_len; k++) begin
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          end
        end
        if (hit) begin
          mz = 1'b1;
          if (!ov_i) m_bits.delete();
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if (m_cnt8 == 255) m_sat8 = 1'b1;
        if (m_cnt2 == 3) m_sat2 = 1'b1;
      end
    end
    exp_q.push_back({mz, merr, m_sat8, 8'(m_cnt8), mz, merr, m_sat2, 2'(m_cnt2)});
  endtask

  task automatic bit_in(input bit b, input bit ov);
    step(1'b1, b, 1'b1, ov, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, p, l, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic stream(input logic [15:0] s, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) bit_in(s[i], ov);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [EXP_W-1:0] e, a;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {z, cfg_err, cnt_sat, match_cnt, z2, err2, sat2, cnt2};
        vec_cnt++;
        if (a !== e) begin
          miscmp++;
          $display("FAIL outputs t=%0t: got z=%b err=%b sat=%b cnt=%0d z2=%b err2=%b sat2=%b cnt2=%0d expected z=%b err=%b sat=%b cnt=%0d z2=%b err2=%b sat2=%b cnt2=%0d",
                   $time, a[15], a[14], a[13], a[12:5], a[4], a[3], a[2], a[1:0],
                   e[15], e[14], e[13], e[12:5], e[4], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  initial begin
    logic [ML-1:0] rp;
    logic [LW-1:0] rl;
    int r;
    model_reset();
    do_reset();

    // default 1100, overlapping then non-overlapping
    stream(16'b111001110011001, 15, 1'b1);
    settle();
    check_val("cnt_1100_ov1", int'(match_cnt), 3);
    load(8'b0000_1100, 4'd4);
    stream(16'b111001110011001, 15, 1'b0);
    settle();
    check_val("cnt_1100_ov0", int'(match_cnt), 3);

    // 101 overlap vs non-overlap
    load(8'b0000_0101, 4'd3);
    stream(16'b10101, 5, 1'b1);
    settle();
    check_val("cnt_101_ov1", int'(match_cnt), 2);
    load(8'b0000_0101, 4'd3);
    stream(16'b10101, 5, 1'b0);
    settle();
    check_val("cnt_101_ov0", int'(match_cnt), 1);

    // single-bit pattern saturates the narrow counter
    load(8'b0000_0001, 4'd1);
    for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
    settle();
    check_val("cnt2_sat_value", int'(cnt2), 3);
    check_val("cnt2_sat_flag", int'(sat2), 1);
    check_val("cnt8_len1", int'(match_cnt), 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    settle();
    check_val("cnt2_after_clr", int'(cnt2), 0);
    check_val("sat2_after_clr", int'(sat2), 0);

    // illegal lengths rejected, default pattern kept
    do_reset();
    load(8'hff, 4'd0);
    load(8'hff, 4'd9);
    settle();
    check_val("cfg_err_len9", int'(cfg_err), 1);
    stream(16'b1100, 4, 1'b1);
    settle();
    check_val("cnt_after_bad_cfg", int'(match_cnt), 1);

    // reset mid-sequence
    stream(16'b110, 3, 1'b1);
    do_reset();
    bit_in(1'b0, 1'b1);
    settle();
    check_val("z_across_reset", int'(z), 0);
    check_val("cnt_across_reset", int'(match_cnt), 0);

    // enable gaps between bits
    do_reset();
    bit_in(1'b1, 1'b1); idle(); idle(); idle();
    bit_in(1'b1, 1'b1); idle(); idle(); idle();
    bit_in(1'b0, 1'b1); idle(); idle(); idle();
    bit_in(1'b0, 1'b1);
    settle();
    check_val("z_gapped", int'(z), 1);
    idle();
    settle();
    check_val("z_gapped_drop", int'(z), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      rp = 8'($urandom);
      rl = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 10));
      step((r == 0) ? 1'b0 : 1'b1, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
           (r >= 1 && r <= 3), rp, rl, (r >= 4 && r <= 5));
    end

    settle();
    settle();
    check_val("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
